// File: rtl/pipe5_datapath.sv
// Five-stage RV64 datapath (IF/ID/EX/MEM/WB) with EX forwarding, load-use stall
// and a forwarding-disable build option. Decode/control lives outside this block.
module pipe5_datapath #(
  parameter int PC_W       = 9,
  parameter int INS_W      = 32,
  parameter int RF_ADDRESS = 5,
  parameter int DATA_W     = 64,
  parameter int DM_ADDRESS = 9,
  parameter int ALU_CC_W   = 4,
  parameter int FWD_EN     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite,
  input  logic                MemtoReg,
  input  logic                ALUsrc,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [ALU_CC_W-1:0] ALU_CC,
  output logic [INS_W-1:0]    instruction,
  output logic [DATA_W-1:0]   ALUresult,
  output logic                stall
);

  localparam int IM_WORDS = 2 ** (PC_W - 2);
  localparam int SH_W     = $clog2(DATA_W);

  localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
  localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
  localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
  localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);
  localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(4'b0111);
  localparam logic [ALU_CC_W-1:0] CC_XOR = ALU_CC_W'(4'b1000);
  localparam logic [ALU_CC_W-1:0] CC_SLL = ALU_CC_W'(4'b1001);
  localparam logic [ALU_CC_W-1:0] CC_SRL = ALU_CC_W'(4'b1010);
  localparam logic [ALU_CC_W-1:0] CC_SRA = ALU_CC_W'(4'b1011);
  localparam logic [ALU_CC_W-1:0] CC_NOR = ALU_CC_W'(4'b1100);

  typedef logic [RF_ADDRESS-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     word_t;

  typedef struct packed {
    logic                reg_write, mem_to_reg, alu_src, mem_write, mem_read;
    logic [ALU_CC_W-1:0] alu_cc;
    word_t               rd1, rd2, imm;
    reg_idx_t            rs1, rs2, rd;
  } id_ex_t;

  typedef struct packed {
    logic     reg_write, mem_to_reg, mem_write, mem_read;
    word_t    alu, store_data;
    reg_idx_t rd;
  } ex_mem_t;

  typedef struct packed {
    logic     reg_write, mem_to_reg;
    word_t    mem_data, alu;
    reg_idx_t rd;
  } mem_wb_t;

  function automatic logic src_hit(input logic we, input reg_idx_t rd, input reg_idx_t rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  // The PC is kept as a word index: byte PC = {pc_word, 2'b00}, so +1 here is +4 in bytes.
  logic [PC_W-3:0] pc_word;
  logic [INS_W-1:0] instr_mem [0:IM_WORDS-1];
  word_t            regs      [0:2**RF_ADDRESS-1];
  word_t            data_mem  [0:2**DM_ADDRESS-1];

  id_ex_t  id_ex, id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;

  reg_idx_t id_rs1, id_rs2, id_rd;
  word_t    id_rd1, id_rd2, id_imm, wb_data, src_a, src_b, op_b, alu_out, mem_rdata;
  logic     wb_we;
  logic [DM_ADDRESS-1:0] dm_addr;

  assign id_rs1 = instruction[15 +: RF_ADDRESS];
  assign id_rs2 = instruction[20 +: RF_ADDRESS];
  assign id_rd  = instruction[7 +: RF_ADDRESS];

  // WB stage
  assign wb_data = mem_wb.mem_to_reg ? mem_wb.mem_data : mem_wb.alu;
  assign wb_we   = mem_wb.reg_write && (mem_wb.rd != '0);

  // Regfile read with same-cycle WB bypass; x0 is hard-wired to zero.
  assign id_rd1 = (id_rs1 == '0) ? '0 : (wb_we && mem_wb.rd == id_rs1) ? wb_data : regs[id_rs1];
  assign id_rd2 = (id_rs2 == '0) ? '0 : (wb_we && mem_wb.rd == id_rs2) ? wb_data : regs[id_rs2];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    id_imm = {{(DATA_W-12){instruction[31]}}, instruction[31:20]};
    case (instruction[6:0])
      7'b0100011: id_imm = {{(DATA_W-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      7'b1100011: id_imm = {{(DATA_W-12){instruction[31]}}, instruction[7], instruction[30:25],
                            instruction[11:8], 1'b0};
      7'b0110111,
      7'b0010111: id_imm = {{(DATA_W-32){instruction[31]}}, instruction[31:12], 12'b0};
      default:    ;
    endcase
  end

  // Load-use (forwarding) or any in-flight producer (no forwarding) freezes IF/ID.
  always_comb begin
    if (FWD_EN != 0)
      stall = src_hit(id_ex.mem_read, id_ex.rd, id_rs1) || src_hit(id_ex.mem_read, id_ex.rd, id_rs2);
    else
      stall = src_hit(id_ex.reg_write, id_ex.rd, id_rs1)  || src_hit(id_ex.reg_write, id_ex.rd, id_rs2) ||
              src_hit(ex_mem.reg_write, ex_mem.rd, id_rs1) || src_hit(ex_mem.reg_write, ex_mem.rd, id_rs2);
  end

  always_comb begin
    id_ex_d = '0;
    if (!stall) begin
      id_ex_d.reg_write  = RegWrite;
      id_ex_d.mem_to_reg = MemtoReg;
      id_ex_d.alu_src    = ALUsrc;
      id_ex_d.mem_write  = MemWrite;
      id_ex_d.mem_read   = MemRead;
      id_ex_d.alu_cc     = ALU_CC;
      id_ex_d.rd1        = id_rd1;
      id_ex_d.rd2        = id_rd2;
      id_ex_d.imm        = id_imm;
      id_ex_d.rs1        = id_rs1;
      id_ex_d.rs2        = id_rs2;
      id_ex_d.rd         = id_rd;
    end
  end

  // EX stage: EX/MEM takes priority over MEM/WB as the younger producer.
  always_comb begin
    src_a = id_ex.rd1;
    src_b = id_ex.rd2;
    if (FWD_EN != 0) begin
      if (src_hit(ex_mem.reg_write, ex_mem.rd, id_ex.rs1))      src_a = ex_mem.alu;
      else if (src_hit(mem_wb.reg_write, mem_wb.rd, id_ex.rs1)) src_a = wb_data;
      if (src_hit(ex_mem.reg_write, ex_mem.rd, id_ex.rs2))      src_b = ex_mem.alu;
      else if (src_hit(mem_wb.reg_write, mem_wb.rd, id_ex.rs2)) src_b = wb_data;
    end
    op_b = id_ex.alu_src ? id_ex.imm : src_b;
    case (id_ex.alu_cc)
      CC_AND:  alu_out = src_a & op_b;
      CC_OR:   alu_out = src_a | op_b;
      CC_ADD:  alu_out = src_a + op_b;
      CC_SUB:  alu_out = src_a - op_b;
      CC_SLT:  alu_out = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(op_b)};
      CC_XOR:  alu_out = src_a ^ op_b;
      CC_SLL:  alu_out = src_a << op_b[SH_W-1:0];
      CC_SRL:  alu_out = src_a >> op_b[SH_W-1:0];
      CC_SRA:  alu_out = word_t'($signed(src_a) >>> op_b[SH_W-1:0]);
      CC_NOR:  alu_out = ~(src_a | op_b);
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex.reg_write;
    ex_mem_d.mem_to_reg = id_ex.mem_to_reg;
    ex_mem_d.mem_write  = id_ex.mem_write;
    ex_mem_d.mem_read   = id_ex.mem_read;
    ex_mem_d.alu        = alu_out;
    ex_mem_d.store_data = src_b;
    ex_mem_d.rd         = id_ex.rd;
  end

  // MEM stage
  assign dm_addr   = ex_mem.alu[DM_ADDRESS-1:0];
  assign mem_rdata = ex_mem.mem_read ? data_mem[dm_addr] : '0;
  assign ALUresult = ex_mem.alu;

  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.reg_write  = ex_mem.reg_write;
    mem_wb_d.mem_to_reg = ex_mem.mem_to_reg;
    mem_wb_d.mem_data   = mem_rdata;
    mem_wb_d.alu        = ex_mem.alu;
    mem_wb_d.rd         = ex_mem.rd;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values together.
    if (reset) begin
      pc_word     <= '0;
      instruction <= '0;
      id_ex       <= '0;
      ex_mem      <= '0;
      mem_wb      <= '0;
    end else begin
      if (!stall) begin
        pc_word     <= pc_word + 1'b1;
        instruction <= instr_mem[pc_word];
      end
      id_ex  <= id_ex_d;
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
    end
  end

  // NOTE: register file and data memory are storage arrays and are deliberately not reset;
  // reset only suppresses writes on its edge.
  always_ff @(posedge clk) begin
    if (!reset && wb_we) regs[mem_wb.rd] <= wb_data;
    if (!reset && ex_mem.mem_write) data_mem[dm_addr] <= ex_mem.store_data;
  end

endmodule

// File: tb/tb_pipe5_datapath.sv
// Directed bench for pipe5_datapath: one forwarding instance (dut1) and one
// stall-only instance (dut0) run the same programs with a small decode model.
module tb_pipe5_datapath;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] instr_0, instr_1;
  logic [63:0] alu_0, alu_1;
  logic        stall_0, stall_1;
  logic [8:0]  ctrl_0, ctrl_1;

  int tests  = 0;
  int failed = 0;

  // Controller model: {RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead, ALU_CC[3:0]}
  function automatic logic [8:0] decode(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return {5'b10000, (ins[30] ? 4'b0110 : 4'b0010)};
      7'b0010011: return {5'b10100, 4'b0010};
      7'b0000011: return {5'b11101, 4'b0010};
      7'b0100011: return {5'b00110, 4'b0010};
      default:    return 9'b0;
    endcase
  endfunction

  assign ctrl_0 = decode(instr_0);
  assign ctrl_1 = decode(instr_1);

  pipe5_datapath #(.FWD_EN(0)) dut0 (
    .clk(clk), .reset(reset),
    .RegWrite(ctrl_0[8]), .MemtoReg(ctrl_0[7]), .ALUsrc(ctrl_0[6]),
    .MemWrite(ctrl_0[5]), .MemRead(ctrl_0[4]), .ALU_CC(ctrl_0[3:0]),
    .instruction(instr_0), .ALUresult(alu_0), .stall(stall_0)
  );

  pipe5_datapath #(.FWD_EN(1)) dut1 (
    .clk(clk), .reset(reset),
    .RegWrite(ctrl_1[8]), .MemtoReg(ctrl_1[7]), .ALUsrc(ctrl_1[6]),
    .MemWrite(ctrl_1[5]), .MemRead(ctrl_1[4]), .ALU_CC(ctrl_1[3:0]),
    .instruction(instr_1), .ALUresult(alu_1), .stall(stall_1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int idx, input logic [31:0] w);
    dut0.instr_mem[idx[6:0]] = w;
    dut1.instr_mem[idx[6:0]] = w;
  endtask

  task automatic load_nops;
    for (int i = 0; i < 128; i++) set_instr(i, NOP);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick;
    reset = 1'b0;
  endtask

  // addi x1,x0,5 ; add x2,x1,x1 ; add x3,x2,x1
  task automatic load_chain;
    load_nops;
    set_instr(0, 32'h00500093);
    set_instr(1, 32'h00108133);
    set_instr(2, 32'h001101B3);
  endtask

  task automatic test_reset;
    load_chain;
    reset = 1'b1;
    repeat (3) tick;
    tests += 6;
    if (instr_0 !== 32'h0) begin $display("FAIL reset instr dut0: got %h want 0", instr_0); failed++; end
    if (instr_1 !== 32'h0) begin $display("FAIL reset instr dut1: got %h want 0", instr_1); failed++; end
    if (alu_0 !== 64'h0)   begin $display("FAIL reset alu dut0: got %h want 0", alu_0); failed++; end
    if (alu_1 !== 64'h0)   begin $display("FAIL reset alu dut1: got %h want 0", alu_1); failed++; end
    if (stall_0 !== 1'b0)  begin $display("FAIL reset stall dut0: got %b want 0", stall_0); failed++; end
    if (stall_1 !== 1'b0)  begin $display("FAIL reset stall dut1: got %b want 0", stall_1); failed++; end
    reset = 1'b0;
    tick;
    tests += 2;
    if (instr_0 !== 32'h00500093) begin $display("FAIL first_fetch dut0: got %h want 00500093", instr_0); failed++; end
    if (instr_1 !== 32'h00500093) begin $display("FAIL first_fetch dut1: got %h want 00500093", instr_1); failed++; end
    tick;
    tests++;
    if (instr_1 !== 32'h00108133) begin $display("FAIL fetch_pc4 dut1: got %h want 00108133", instr_1); failed++; end
    tick;
    tests += 3;
    if (instr_1 !== 32'h001101B3) begin $display("FAIL fetch_pc8 dut1: got %h want 001101b3", instr_1); failed++; end
    if (alu_1 !== 64'd5) begin $display("FAIL first_result dut1: got %0d want 5", alu_1); failed++; end
    if (stall_1 !== 1'b0) begin $display("FAIL first_stall dut1: got %b want 0", stall_1); failed++; end
  endtask

  task automatic test_alu_chain;
    int  ea1 [9];
    int  ea0 [9];
    bit  es0 [9];
    ea1 = '{0, 0, 5, 10, 15, 0, 0, 0, 0};
    ea0 = '{0, 0, 5, 0, 0, 10, 0, 0, 15};
    es0 = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
    load_chain;
    do_reset(3);
    for (int e = 0; e < 9; e++) begin
      tick;
      tests += 4;
      if (alu_1 !== 64'(ea1[e])) begin $display("FAIL chain_fwd alu edge %0d: got %0d want %0d", e + 1, alu_1, ea1[e]); failed++; end
      if (stall_1 !== 1'b0)      begin $display("FAIL chain_fwd stall edge %0d: got %b want 0", e + 1, stall_1); failed++; end
      if (alu_0 !== 64'(ea0[e])) begin $display("FAIL chain_nofwd alu edge %0d: got %0d want %0d", e + 1, alu_0, ea0[e]); failed++; end
      if (stall_0 !== es0[e])    begin $display("FAIL chain_nofwd stall edge %0d: got %b want %b", e + 1, stall_0, es0[e]); failed++; end
    end
  endtask

  // addi x0,x0,7 ; add x6,x0,x0 ; add x6,x0,x0
  task automatic test_x0;
    int ea [5];
    ea = '{0, 0, 7, 0, 0};
    load_nops;
    set_instr(0, 32'h00700013);
    set_instr(1, 32'h00000333);
    set_instr(2, 32'h00000333);
    do_reset(3);
    for (int e = 0; e < 5; e++) begin
      tick;
      tests += 4;
      if (alu_1 !== 64'(ea[e])) begin $display("FAIL x0 alu dut1 edge %0d: got %0d want %0d", e + 1, alu_1, ea[e]); failed++; end
      if (alu_0 !== 64'(ea[e])) begin $display("FAIL x0 alu dut0 edge %0d: got %0d want %0d", e + 1, alu_0, ea[e]); failed++; end
      if (stall_1 !== 1'b0)     begin $display("FAIL x0 stall dut1 edge %0d: got %b want 0", e + 1, stall_1); failed++; end
      if (stall_0 !== 1'b0)     begin $display("FAIL x0 stall dut0 edge %0d: got %b want 0", e + 1, stall_0); failed++; end
    end
  endtask

  // addi x1,x0,5 ; sd x1,0(x0) ; ld x4,0(x0) ; add x5,x4,x4 ; addi x7,x5,0
  task automatic test_load_use;
    int ea [8];
    bit es [8];
    ea = '{0, 0, 5, 0, 0, 0, 10, 10};
    es = '{0, 0, 0, 1, 0, 0, 0, 0};
    load_nops;
    set_instr(0, 32'h00500093);
    set_instr(1, 32'h00103023);
    set_instr(2, 32'h00003203);
    set_instr(3, 32'h004202B3);
    set_instr(4, 32'h00028393);
    do_reset(3);
    for (int e = 0; e < 8; e++) begin
      tick;
      tests += 2;
      if (alu_1 !== 64'(ea[e])) begin $display("FAIL load_use alu edge %0d: got %0d want %0d", e + 1, alu_1, ea[e]); failed++; end
      if (stall_1 !== es[e])    begin $display("FAIL load_use stall edge %0d: got %b want %b", e + 1, stall_1, es[e]); failed++; end
      if (e == 4) begin
        tests++;
        if (instr_1 !== 32'h004202B3) begin $display("FAIL load_use hold edge 5: got %h want 004202b3", instr_1); failed++; end
      end
    end
  endtask

  // addi x1,x0,9 ; sd x1,0(x0) ; ld x4,0(x0) ; add x5,x4,x4 -- reset lands mid-stall,
  // so x1 must keep 5 and mem[0] must keep 5 from the previous program.
  task automatic test_reset_mid_stall;
    int ea [5];
    ea = '{0, 0, 0, 5, 5};
    load_nops;
    set_instr(0, 32'h00900093);
    set_instr(1, 32'h00103023);
    set_instr(2, 32'h00003203);
    set_instr(3, 32'h004202B3);
    do_reset(3);
    repeat (4) tick;
    tests++;
    if (stall_1 !== 1'b1) begin $display("FAIL mid_stall pre-reset stall: got %b want 1", stall_1); failed++; end
    reset = 1'b1;
    tick;
    tests += 3;
    if (instr_1 !== 32'h0) begin $display("FAIL mid_stall reset instr: got %h want 0", instr_1); failed++; end
    if (alu_1 !== 64'h0)   begin $display("FAIL mid_stall reset alu: got %h want 0", alu_1); failed++; end
    if (stall_1 !== 1'b0)  begin $display("FAIL mid_stall reset stall: got %b want 0", stall_1); failed++; end
    // probe: ld x4,0(x0) ; add x8,x1,x0 ; addi x7,x4,0
    set_instr(0, 32'h00003203);
    set_instr(1, 32'h00008433);
    set_instr(2, 32'h00020393);
    set_instr(3, NOP);
    tick;
    reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick;
      tests += 2;
      if (alu_1 !== 64'(ea[e])) begin $display("FAIL mid_stall probe alu edge %0d: got %0d want %0d", e + 1, alu_1, ea[e]); failed++; end
      if (stall_1 !== 1'b0)     begin $display("FAIL mid_stall probe stall edge %0d: got %b want 0", e + 1, stall_1); failed++; end
      if (e == 0) begin
        tests++;
        if (instr_1 !== 32'h00003203) begin $display("FAIL mid_stall restart fetch: got %h want 00003203", instr_1); failed++; end
      end
    end
  endtask

  task automatic test_pc_wrap;
    load_nops;
    set_instr(0, 32'h00100013);
    set_instr(127, 32'h00200013);
    do_reset(3);
    repeat (128) tick;
    tests += 2;
    if (instr_1 !== 32'h00200013) begin $display("FAIL wrap last dut1: got %h want 00200013", instr_1); failed++; end
    if (instr_0 !== 32'h00200013) begin $display("FAIL wrap last dut0: got %h want 00200013", instr_0); failed++; end
    tick;
    tests += 2;
    if (instr_1 !== 32'h00100013) begin $display("FAIL wrap first dut1: got %h want 00100013", instr_1); failed++; end
    if (instr_0 !== 32'h00100013) begin $display("FAIL wrap first dut0: got %h want 00100013", instr_0); failed++; end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_alu_chain;
    test_x0;
    test_load_use;
    test_reset_mid_stall;
    test_pc_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
